// File: rtl/ik_jacobian_pkg.sv
// Shared fixed-point types, FSM state encoding and the lane subtract helper.
// Defining JACOBIAN_SAT_EN makes every subtraction saturate instead of wrap.
package ik_jacobian_pkg;

  localparam int FRAC_BITS = 16;
  localparam int WORD_W    = 36;

  typedef logic signed [WORD_W-1:0] fixed_t;
  typedef fixed_t [2:0] vec3_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SUB,
    ST_ISSUE,
    ST_WAIT,
    ST_ACC,
    ST_DONE
  } jac_state_e;

  localparam fixed_t ONE_FX = fixed_t'(1) <<< FRAC_BITS;
  localparam fixed_t MAX_FX = {1'b0, {(WORD_W-1){1'b1}}};
  localparam fixed_t MIN_FX = {1'b1, {(WORD_W-1){1'b0}}};

  // One extra bit of headroom exposes overflow as a mismatch of the top two bits.
  function automatic fixed_t sub_fx(input fixed_t a, input fixed_t b);
    logic signed [WORD_W:0] diff;
    diff = {a[WORD_W-1], a} - {b[WORD_W-1], b};
`ifdef JACOBIAN_SAT_EN
    if (diff[WORD_W] != diff[WORD_W-1]) begin
      return diff[WORD_W] ? MIN_FX : MAX_FX;
    end
`else
`endif
    return fixed_t'(diff[WORD_W-1:0]);
  endfunction

endpackage

// File: rtl/jacobian_cols_if.sv
// Bus to the six shared array multipliers borrowed by the Jacobian stage.
interface jacobian_cols_if;
  import ik_jacobian_pkg::*;

  logic [5:0][WORD_W-1:0] array_mult_dataa;
  logic [5:0][WORD_W-1:0] array_mult_datab;
  logic [5:0][WORD_W-1:0] array_mult_result;

  modport master (
    output array_mult_dataa,
    output array_mult_datab,
    input  array_mult_result
  );

  modport slave (
    input  array_mult_dataa,
    input  array_mult_datab,
    output array_mult_result
  );

endinterface

// File: rtl/jac_vec_sub.sv
// Three independent combinational lanes computing a - b (wrap or saturate,
// selected by JACOBIAN_SAT_EN inside sub_fx).
module jac_vec_sub
  import ik_jacobian_pkg::*;
(
  input  vec3_t a_i,
  input  vec3_t b_i,
  output vec3_t y_o
);

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_lane
      assign y_o[gi] = sub_fx(a_i[gi], b_i[gi]);
    end
  endgenerate

endmodule

// File: rtl/jacobian_cols.sv
// Builds the 6x6 geometric Jacobian one column at a time, time-sharing six
// external multipliers for each cross product. JACOBIAN_SAT_EN: saturating subtracts.
module jacobian_cols
  import ik_jacobian_pkg::*;
#(
  parameter int MULT_LAT = 2
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               en,
  input  logic [5:0][3:0][3:0][WORD_W-1:0]   full_matrix,
  jacobian_cols_if.master                    mult,
  output logic [5:0][5:0][WORD_W-1:0]        jacobian,
  output logic                               busy,
  output logic                               done
);

  // Only meaningful when MULT_LAT > 1; WAIT is skipped otherwise.
  localparam logic [2:0] WAIT_LAST = 3'(MULT_LAT - 2);

  jac_state_e                    state_q, state_d;
  logic [2:0]                    col_q, col_d;
  logic [2:0]                    wait_q, wait_d;
  logic [2:0]                    frame_sel;
  vec3_t                         d_q, d_d;
  vec3_t                         z_w, o_w, on_w, d_w;
  logic [5:0][5:0][WORD_W-1:0]   jac_q, jac_d;
  logic                          ops_en;

  assign frame_sel = col_q - 3'd1;

  // Column 0 uses the base frame: z along the world z axis, origin at zero.
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_axis
      assign on_w[gi] = full_matrix[5][gi][3];
      assign z_w[gi]  = (col_q == 3'd0) ? ((gi == 2) ? ONE_FX : '0)
                                        : full_matrix[frame_sel][gi][2];
      assign o_w[gi]  = (col_q == 3'd0) ? '0 : full_matrix[frame_sel][gi][3];
    end
  endgenerate

  jac_vec_sub u_d_sub (
    .a_i (on_w),
    .b_i (o_w),
    .y_o (d_w)
  );

  assign ops_en = state_q inside {ST_ISSUE, ST_WAIT, ST_ACC};

  // Lanes 0..5 form the six partial products of z x d (concat is lane5..lane0).
  always_comb begin
    mult.array_mult_dataa = '0;
    mult.array_mult_datab = '0;
    if (ops_en) begin
      mult.array_mult_dataa = {z_w[1], z_w[0], z_w[0], z_w[2], z_w[2], z_w[1]};
      mult.array_mult_datab = {d_q[0], d_q[1], d_q[2], d_q[0], d_q[1], d_q[2]};
    end
  end

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    wait_d  = wait_q;
    d_d     = d_q;
    jac_d   = jac_q;
    case (state_q)
      ST_IDLE: begin
        if (en) begin
          state_d = ST_SUB;
          col_d   = '0;
        end
      end
      ST_SUB: begin
        d_d     = d_w;
        state_d = ST_ISSUE;
      end
      ST_ISSUE: begin
        wait_d  = '0;
        state_d = (MULT_LAT == 1) ? ST_ACC : ST_WAIT;
      end
      ST_WAIT: begin
        if (wait_q == WAIT_LAST) state_d = ST_ACC;
        else                     wait_d  = wait_q + 3'd1;
      end
      ST_ACC: begin
        jac_d[col_q][0] = sub_fx(mult.array_mult_result[0], mult.array_mult_result[1]);
        jac_d[col_q][1] = sub_fx(mult.array_mult_result[2], mult.array_mult_result[3]);
        jac_d[col_q][2] = sub_fx(mult.array_mult_result[4], mult.array_mult_result[5]);
        jac_d[col_q][3] = z_w[0];
        jac_d[col_q][4] = z_w[1];
        jac_d[col_q][5] = z_w[2];
        if (col_q == 3'd5) begin
          state_d = ST_DONE;
        end else begin
          col_d   = col_q + 3'd1;
          state_d = ST_SUB;
        end
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      col_q   <= '0;
      wait_q  <= '0;
      d_q     <= '0;
      jac_q   <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      wait_q  <= wait_d;
      d_q     <= d_d;
      jac_q   <= jac_d;
    end
  end

  assign jacobian = jac_q;
  assign busy     = (state_q != ST_IDLE);
  assign done     = (state_q == ST_DONE);

endmodule

// File: doc/jacobian_cols.md
# jacobian_cols

Downstream stage of the full-matrix block in the full-Jacobian path. Consumes the six cumulative transforms T0^1..T0^6 (`full_matrix`) and builds the 6x6 geometric Jacobian for six revolute joints, one column at a time. Borrows the six shared array multipliers for one cross product per joint, so all six cross products are time-multiplexed.

## Interface
Parameters:
- `MULT_LAT`, default 2: cycles from operands driven on `array_mult_data*` to product valid on `array_mult_result`. Legal range 1..7.

Ports:
- `clk`  in  1: clock.
- `rst`  in  1: reset. Synchronous and active-high.
- `en`  in  1: start pulse. Sampled only in IDLE.
- `full_matrix`  in  [5:0][3:0][3:0][35:0]: the transforms, indexed `[k][row][col]`, where k=0..5 is T0^(k+1). Must be held stable from start until `done`.
- `array_mult_result`  in  [5:0][35:0]: shared multiplier products, already rescaled to Q.FRAC_BITS.
- `array_mult_dataa`  out  [5:0][35:0]: first operand of each shared multiplier.
- `array_mult_datab`  out  [5:0][35:0]: second operand of each shared multiplier.
- `jacobian`  out  [5:0][5:0][35:0]: the Jacobian, indexed `[col][row]`. Rows 0-2 are linear, rows 3-5 are angular.
- `busy`  out  1: high in every state except IDLE.
- `done`  out  1: one-cycle pulse when all 6 columns are written.

## Operation
- Arithmetic: signed two's complement, 36 bits, Q.FRAC_BITS; 1.0 = 65536.
- Endpoint: o_n = `full_matrix[5][0..2][3]`.
- Column i uses frame i-1:
  - z = `full_matrix[i-1][0..2][2]`, o = `full_matrix[i-1][0..2][3]`.
  - For i=0: z=(0,0,65536) and o=(0,0,0).
- Column formulas:
  - d = o_n − o.
  - Jv = z × d.
  - Jw = z.
- FSM states: IDLE, SUB, ISSUE, WAIT, ACC, DONE.
- Transitions:
  - IDLE→SUB on `en`; column counter i=0.
  - SUB: register d (3 subtractions) → ISSUE.
  - ISSUE: drive lanes 0..5 with dataa = (zy, zz, zz, zx, zx, zy) and datab = (dz, dy, dx, dz, dy, dx). Go to WAIT, or go straight to ACC if MULT_LAT=1.
  - WAIT: stay for MULT_LAT−1 cycles.
  - ACC:
    - `jacobian[i][0]` = r0−r1, `[i][1]` = r2−r3, `[i][2]` = r4−r5.
    - `[i][3..5]` = z.
    - If i=5 → DONE; else i++ → SUB.
  - DONE: `done`=1 for one cycle → IDLE.
- Operand outputs:
  - Held from ISSUE through ACC.
  - Zero in IDLE, SUB and DONE.
- `jacobian` retains its last value until overwritten column by column during the next run. It is not cleared on start.
- Subtractions (d, and the pair differences in ACC) wrap modulo 2^36 by default.

## Timing
- Per column: MULT_LAT+2 cycles.
- `en` high in IDLE at cycle 0 gives:
  - SUB at cycle 1.
  - `done` high at cycle 1+6·(MULT_LAT+2): cycle 25 for MULT_LAT=2.
  - IDLE again at the following cycle.
- Column i becomes visible on `jacobian` the cycle after its ACC.
- `en` while busy (including DONE) is ignored; no queuing.
- `rst` at any time takes effect at the next edge:
  - State IDLE, i=0.
  - `jacobian`, `array_mult_data*`, `done` and `busy` are all 0.
  - An in-flight run is abandoned.
- Reset value of every output is 0.
- `rst` and `en` in the same cycle: reset wins.

## Configuration
- `JACOBIAN_SAT_EN` defined: all subtractions (d and the ACC pair differences) saturate to [−2^35, 2^35−1].
- Without it: two's-complement wrap.
- Latency is identical in both builds.

## Structure
- Package `ik_jacobian_pkg` holds:
  - `FRAC_BITS=16` and `WORD_W=36`.
  - `fixed_t` (`logic signed [35:0]`) and `vec3_t`.
  - The state enum `jac_state_e`.
  - A `ONE_FX` constant.
- One sub-module, `jac_vec_sub`: a 3-lane registered-input-free subtractor (a−b per lane), with saturation under `JACOBIAN_SAT_EN`. Instantiated for d; its lane function is reused for the ACC differences.

## Test plan
The bench models the shared multipliers as ((a*b)>>>16) truncated to 36 bits, delayed MULT_LAT cycles.

- **Identity transforms:** all T = identity, then `full_matrix[5][0][3]`=65536, then `en` → every column reads Jv=(0,65536,0), Jw=(0,0,65536); `done` at cycle 25.
- **Planar 2-link, T0^1 origin (65536,0,0), z all (0,0,65536), o_n=(131072,0,0):**
  - Col 0: Jv=(0,131072,0).
  - Col 1: Jv=(0,65536,0).
  - Cols 2..5: Jv=0.
- **Reset mid-run:** `rst` at cycle 10 → all outputs 0 next cycle, `busy`=0; a fresh `en` completes normally.
- **`en` pulsed at cycles 5 and 25:** ignored; exactly one `done` pulse at 25; no restart.
- **Overflow, o_n x = 2^35−1 and o x = −65536:**
  - Without the macro, dx wraps to −2^35+65535.
  - With `JACOBIAN_SAT_EN`, dx = 2^35−1.
  - Check the resulting Jv y entry in both builds.
- **MULT_LAT=1 and MULT_LAT=3:** `done` at cycles 19 and 31. Operands stay stable and nonzero from ISSUE through ACC only.
